tt_proj_mux_ctrl: RTL and testbench

//  Selects one of N_PROJ wrapped projects (18-bit iw / 24-bit ow bundles) and gives it exclusive use of
//  the shared pins. Drives a one-hot ena, broadcasts host pins into the shared iw bus, and returns the

---
 rtl/tt_proj_mux_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_tt_proj_mux_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_proj_mux_ctrl.sv
// -----------------------------------------------------------------------------
// tt_proj_mux_ctrl
//
// Shares one set of host pins between N_PROJ wrapped projects. A pending
// address is stepped by sel_inc pulses and cleared by sel_rst_n. While sel_ena
// is high, the project at the pending address gets a one-hot ena, the host pin
// bundle on its iw inputs, and its ow bundle routed back to the host. Every
// enable and every disable is wrapped in a guard interval. During that interval
// the project is enabled but sees clk=0 and rst_n=0 on its iw bundle.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   sel_rst_n  async pin, active-low: clears the pending address
//   sel_inc    async pin: each rising edge steps the pending address (wraps)
//   sel_ena    async pin, level: enable the project at the pending address
//   host_iw    host pin bundle {uio_in, ui_in, rst_n, clk}
//   proj_ow    flattened project outputs, project k at [k*OW +: OW]
//   proj_iw    shared iw bus to all wrappers (registered)
//   proj_ena   one-hot or all-zero enable to the wrappers (registered)
//   host_ow    selected project's ow bundle (registered)
//   cur_addr   address of the active or settling project
//   busy       high while a guard interval (settle or drain) is running
// -----------------------------------------------------------------------------
module tt_proj_mux_ctrl #(
    parameter int N_PROJ       = 16,
    parameter int AW           = $clog2(N_PROJ),
    parameter int IW           = 18,
    parameter int OW           = 24,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sel_rst_n,
    input  logic                 sel_inc,
    input  logic                 sel_ena,
    input  logic [IW-1:0]        host_iw,
    input  logic [N_PROJ*OW-1:0] proj_ow,
    output logic [IW-1:0]        proj_iw,
    output logic [N_PROJ-1:0]    proj_ena,
    output logic [OW-1:0]        host_ow,
    output logic [AW-1:0]        cur_addr,
    output logic                 busy
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SETTLE,
        ST_ACTIVE,
        ST_DRAIN
    } state_t;

    state_t        state;
    logic [GW-1:0] gcnt;
    logic [AW-1:0] pending;

    logic sel_rst_n_p0, sel_rst_n_s;
    logic sel_inc_p0, sel_inc_s, sel_inc_q;
    logic sel_ena_p0, sel_ena_s;
    logic inc_edge;
    logic leave_req;

    logic [OW-1:0] proj_ow_arr [N_PROJ];

    function automatic logic [N_PROJ-1:0] onehot(input logic [AW-1:0] a);
        logic [N_PROJ-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == AW'(N_PROJ - 1)) ? '0 : a + AW'(1);
    endfunction

    for (genvar k = 0; k < N_PROJ; k++) begin : g_ow_split
        assign proj_ow_arr[k] = proj_ow[k*OW +: OW];
    end

    assign inc_edge  = sel_inc_s & ~sel_inc_q;
    // Any change of the requested project (or a drop of ena) tears the current one down.
    assign leave_req = ~sel_ena_s | (pending != cur_addr);

    // ---- stage: pin synchronizers and pending address ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_rst_n_p0 <= 1'b1;
            sel_rst_n_s  <= 1'b1;
            sel_inc_p0   <= 1'b0;
            sel_inc_s    <= 1'b0;
            sel_inc_q    <= 1'b0;
            sel_ena_p0   <= 1'b0;
            sel_ena_s    <= 1'b0;
            pending      <= '0;
        end else begin
            sel_rst_n_p0 <= sel_rst_n;
            sel_rst_n_s  <= sel_rst_n_p0;
            sel_inc_p0   <= sel_inc;
            sel_inc_s    <= sel_inc_p0;
            sel_inc_q    <= sel_inc_s;
            sel_ena_p0   <= sel_ena;
            sel_ena_s    <= sel_ena_p0;
            // The clear pin outranks a coincident increment.
            if (!sel_rst_n_s) begin
                pending <= '0;
            end else if (inc_edge) begin
                pending <= next_addr(pending);
            end
        end
    end

    // ---- stage: selection FSM and registered outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_OFF;
            gcnt     <= '0;
            cur_addr <= '0;
            proj_ena <= '0;
            proj_iw  <= '0;
            host_ow  <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    proj_ena <= '0;
                    proj_iw  <= '0;
                    host_ow  <= '0;
                    busy     <= 1'b0;
                    if (sel_ena_s) begin
                        cur_addr <= pending;
                        gcnt     <= GW'(GUARD_CYCLES);
                        proj_ena <= onehot(pending);
                        busy     <= 1'b1;
                        state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Project is enabled but held with clk low and in reset.
                    proj_iw <= '0;
                    host_ow <= '0;
                    gcnt    <= gcnt - GW'(1);
                    if (leave_req) begin
                        gcnt  <= GW'(GUARD_CYCLES);
                        busy  <= 1'b1;
                        state <= ST_DRAIN;
                    end else if (gcnt == GW'(1)) begin
                        busy  <= 1'b0;
                        state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (leave_req) begin
                        proj_iw <= '0;
                        host_ow <= '0;
                        gcnt    <= GW'(GUARD_CYCLES);
                        busy    <= 1'b1;
                        state   <= ST_DRAIN;
                    end else begin
                        proj_iw <= host_iw;
                        host_ow <= proj_ow_arr[cur_addr];
                    end
                end
                ST_DRAIN: begin
                    // Keep ena up while the project sits in reset, then drop it;
                    // OFF always lasts at least one cycle before the next SETTLE.
                    proj_iw <= '0;
                    host_ow <= '0;
                    gcnt    <= gcnt - GW'(1);
                    if (gcnt == GW'(1)) begin
                        proj_ena <= '0;
                        busy     <= 1'b0;
                        state    <= ST_OFF;
                    end
                end
                default: begin
                    proj_ena <= '0;
                    proj_iw  <= '0;
                    host_ow  <= '0;
                    busy     <= 1'b0;
                    state    <= ST_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_proj_mux_ctrl.sv
module tb_tt_proj_mux_ctrl;

    localparam int N_PROJ = 16;
    localparam int IW     = 18;
    localparam int OW     = 24;

    typedef struct packed {
        logic [15:0] ena;
        logic [17:0] iw;
        logic [23:0] ow;
        logic [3:0]  addr;
        logic        busy;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 sel_rst_n;
    logic                 sel_inc;
    logic                 sel_ena;
    logic [IW-1:0]        host_iw;
    logic [N_PROJ*OW-1:0] proj_ow;
    logic [IW-1:0]        proj_iw;
    logic [N_PROJ-1:0]    proj_ena;
    logic [OW-1:0]        host_ow;
    logic [3:0]           cur_addr;
    logic                 busy;

    exp_t  sb[$];
    string sb_tag[$];
    int    checks = 0;
    int    errors = 0;

    tt_proj_mux_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel_rst_n (sel_rst_n),
        .sel_inc   (sel_inc),
        .sel_ena   (sel_ena),
        .host_iw   (host_iw),
        .proj_ow   (proj_ow),
        .proj_iw   (proj_iw),
        .proj_ena  (proj_ena),
        .host_ow   (host_ow),
        .cur_addr  (cur_addr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ow_of(input int k);
        return {8'hA0 + 8'(k), 8'h5A, 8'(k)};
    endfunction

    function automatic logic [15:0] oh(input int a);
        return 16'h0001 << a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [15:0] ena, input logic [17:0] iw,
                        input logic [23:0] ow, input int addr, input logic b);
        exp_t e;
        e.ena  = ena;
        e.iw   = iw;
        e.ow   = ow;
        e.addr = 4'(addr);
        e.busy = b;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic push_off(input int a);    push("off",    16'h0, 18'h0, 24'h0, a, 1'b0); endtask
    task automatic push_settle(input int a); push("settle", oh(a), 18'h0, 24'h0, a, 1'b1); endtask
    task automatic push_act0(input int a);   push("act0",   oh(a), 18'h0, 24'h0, a, 1'b0); endtask
    task automatic push_act(input int a);    push("active", oh(a), host_iw, ow_of(a), a, 1'b0); endtask
    task automatic push_drain(input int a);  push("drain",  oh(a), 18'h0, 24'h0, a, 1'b1); endtask

    task automatic cmp(input exp_t e, input string tag);
        checks++;
        assert (proj_ena === e.ena) else begin
            errors++;
            $error("FAIL %s proj_ena observed=%h expected=%h", tag, proj_ena, e.ena);
        end
        checks++;
        assert (proj_iw === e.iw) else begin
            errors++;
            $error("FAIL %s proj_iw observed=%h expected=%h", tag, proj_iw, e.iw);
        end
        checks++;
        assert (host_ow === e.ow) else begin
            errors++;
            $error("FAIL %s host_ow observed=%h expected=%h", tag, host_ow, e.ow);
        end
        checks++;
        assert (cur_addr === e.addr) else begin
            errors++;
            $error("FAIL %s cur_addr observed=%h expected=%h", tag, cur_addr, e.addr);
        end
        checks++;
        assert (busy === e.busy) else begin
            errors++;
            $error("FAIL %s busy observed=%b expected=%b", tag, busy, e.busy);
        end
    endtask

    // One scoreboard entry is consumed per clock edge.
    task automatic expect_all();
        while (sb.size() > 0) begin
            tick();
            cmp(sb.pop_front(), sb_tag.pop_front());
        end
    endtask

    // Compare the front entry right now, without waiting for a clock edge.
    task automatic check_now();
        cmp(sb.pop_front(), sb_tag.pop_front());
    endtask

    task automatic pulse_inc();
        sel_inc = 1'b1;
        tick();
        tick();
        sel_inc = 1'b0;
        tick();
        tick();
    endtask

    // Raise sel_ena from OFF: 2 sync cycles, 4 settle cycles, then active.
    task automatic visit(input int a, input int last_a);
        sel_ena = 1'b1;
        push_off(last_a);
        push_off(last_a);
        for (int i = 0; i < 4; i++) push_settle(a);
        push_act0(a);
        push_act(a);
        expect_all();
    endtask

    // Drop sel_ena while active: 2 sync cycles, 4 drain cycles, then OFF.
    task automatic leave(input int a);
        sel_ena = 1'b0;
        push_act(a);
        push_act(a);
        for (int i = 0; i < 4; i++) push_drain(a);
        push_off(a);
        expect_all();
    endtask

    initial begin
        rst_n     = 1'b0;
        sel_rst_n = 1'b1;
        sel_inc   = 1'b0;
        sel_ena   = 1'b0;
        host_iw   = 18'h2A5A5;
        for (int k = 0; k < N_PROJ; k++) proj_ow[k*OW +: OW] = ow_of(k);

        // Reset state, both while held and after release.
        #12;
        push_off(0);
        check_now();
        tick();
        rst_n = 1'b1;
        push_off(0);
        push_off(0);
        expect_all();

        // Three increments, then enable project 3.
        pulse_inc();
        pulse_inc();
        pulse_inc();
        visit(3, 0);
        host_iw = 18'h15A5A;
        push_act(3);
        expect_all();

        // Increment while active on 3: full drain, idle, settle onto 4.
        sel_inc = 1'b1;
        push_act(3);
        push_act(3);
        expect_all();
        sel_inc = 1'b0;
        push_act(3);
        for (int i = 0; i < 4; i++) push_drain(3);
        push_off(3);
        for (int i = 0; i < 4; i++) push_settle(4);
        push_act0(4);
        push_act(4);
        expect_all();

        // Drop enable while active on 4.
        leave(4);
        push_off(4);
        expect_all();

        // Clear, then walk to the last address and wrap back to 0.
        sel_rst_n = 1'b0;
        tick();
        tick();
        tick();
        sel_rst_n = 1'b1;
        tick();
        tick();
        tick();
        for (int i = 0; i < 15; i++) pulse_inc();
        visit(15, 4);
        leave(15);
        pulse_inc();
        visit(0, 15);
        leave(0);

        // Increment coincident with clear: clear wins.
        pulse_inc();
        sel_rst_n = 1'b0;
        sel_inc   = 1'b1;
        tick();
        tick();
        sel_rst_n = 1'b1;
        sel_inc   = 1'b0;
        tick();
        tick();
        tick();
        visit(0, 0);
        leave(0);

        // Async reset during SETTLE on project 2.
        pulse_inc();
        pulse_inc();
        sel_ena = 1'b1;
        push_off(0);
        push_off(0);
        push_settle(2);
        push_settle(2);
        expect_all();
        rst_n = 1'b0;
        #2;
        push_off(0);
        check_now();
        tick();
        rst_n = 1'b1;
        visit(0, 0);
        leave(0);

        // Async reset during ACTIVE on project 2.
        pulse_inc();
        pulse_inc();
        visit(2, 0);
        rst_n   = 1'b0;
        sel_ena = 1'b0;
        #2;
        push_off(0);
        check_now();
        tick();
        rst_n = 1'b1;
        push_off(0);
        push_off(0);
        push_off(0);
        expect_all();
        visit(0, 0);
        leave(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
